// File: rtl/slave_response_assembler.sv
// slave_response_assembler
//   Collects the per-byte responses from the slave command-to-SPI stage into
//   frames. The frame length comes from the issued command. Frames are buffered
//   in a first-word fall-through byte FIFO and presented on a valid/ready stream
//   with an end-of-frame marker. The block also flags stray bytes, response
//   timeouts and dropped writes.
//   Optional feature macro: CHECKSUM_EN. When defined, an XOR checksum entry is
//   appended to each frame and carries the end-of-frame marker.
`timescale 1ns/1ps

module slave_response_assembler #(
   parameter int DEPTH          = 16,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [2:0] command,
   output logic       busy,
   input  logic       valid_in,
   input  logic [7:0] rx_byte,
   output logic [7:0] out_data,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       out_last,
   output logic       frame_err,
   output logic       timeout,
   output logic       overflow,
   input  logic       clr_err
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam int TW = $clog2(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COLLECT = 2'd1,
      S_CKSUM   = 2'd2
   } state_t;

   state_t          r_state;
   logic [3:0]      r_remaining;
   logic [TW-1:0]   r_timer;
   logic [7:0]      r_xor;
   logic            r_frame_err;
   logic            r_timeout;
   logic            r_overflow;
   logic [PW-1:0]   r_wr_ptr;
   logic [PW-1:0]   r_rd_ptr;
   logic [8:0]      r_mem [DEPTH];

   state_t          w_state_nxt;
   logic [3:0]      w_remaining_nxt;
   logic [TW-1:0]   w_timer_nxt;
   logic [7:0]      w_xor_nxt;
   logic            w_wr_req;
   logic [8:0]      w_wr_entry;
   logic            w_frame_err_nxt;
   logic            w_timeout_nxt;
   logic            w_full;
   logic            w_empty;
   logic            w_wr_en;
   logic            w_rd_en;
   logic [8:0]      w_head;

   // Full/empty come from the extra pointer MSB. Full is decided before any same-cycle read.
   assign w_empty = (r_wr_ptr == r_rd_ptr);
   assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_wr_en = w_wr_req & ~w_full;
   assign w_rd_en = out_ready & ~w_empty;

   // Frame FSM: next state, counters and the FIFO write request.
   always_comb begin
      // NOTE: every signal gets a default first so that no path through the case leaves one unassigned and infers a latch.
      w_state_nxt     = r_state;
      w_remaining_nxt = r_remaining;
      w_timer_nxt     = r_timer;
      w_xor_nxt       = r_xor;
      w_wr_req        = 1'b0;
      w_wr_entry      = 9'd0;
      w_frame_err_nxt = 1'b0;
      w_timeout_nxt   = 1'b0;
      case (r_state)
         S_IDLE: begin
            // A byte with no command outstanding is stray. It is flagged even if start arrives in the same cycle.
            if (valid_in) w_frame_err_nxt = 1'b1;
            if (start) begin
               w_remaining_nxt = {1'b0, command} + 4'd1;
               w_timer_nxt     = '0;
               w_xor_nxt       = 8'd0;
               w_state_nxt     = S_COLLECT;
            end
         end
         S_COLLECT: begin
            if (valid_in) begin
               w_wr_req        = 1'b1;
               w_remaining_nxt = r_remaining - 4'd1;
               w_xor_nxt       = r_xor ^ rx_byte;
               w_timer_nxt     = '0;
               w_wr_entry      = {1'b0, rx_byte};
               if (r_remaining == 4'd1) begin
`ifdef CHECKSUM_EN
                  w_state_nxt = S_CKSUM;
`else
                  w_wr_entry  = {1'b1, rx_byte};
                  w_state_nxt = S_IDLE;
`endif
               end
            end else if (r_timer == TW'(TIMEOUT_CYCLES - 1)) begin
               // Abort: terminate the frame with a marked filler byte so the consumer still sees its end.
               w_wr_req        = 1'b1;
               w_wr_entry      = {1'b1, 8'hFF};
               w_timeout_nxt   = 1'b1;
               w_frame_err_nxt = 1'b1;
               w_state_nxt     = S_IDLE;
            end else begin
               w_timer_nxt = r_timer + 1'b1;
            end
         end
`ifdef CHECKSUM_EN
         S_CKSUM: begin
            // The checksum entry waits for space instead of being dropped.
            if (!w_full) begin
               w_wr_req    = 1'b1;
               w_wr_entry  = {1'b1, r_xor};
               w_state_nxt = S_IDLE;
            end
         end
`endif
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // FSM state, frame counters and the registered error pulses.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= S_IDLE;
         r_remaining <= 4'd0;
         r_timer     <= '0;
         r_xor       <= 8'd0;
         r_frame_err <= 1'b0;
         r_timeout   <= 1'b0;
      end else begin
         // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values regardless of statement order.
         r_state     <= w_state_nxt;
         r_remaining <= w_remaining_nxt;
         r_timer     <= w_timer_nxt;
         r_xor       <= w_xor_nxt;
         r_frame_err <= w_frame_err_nxt;
         r_timeout   <= w_timeout_nxt;
      end
   end

   // FIFO pointers and sticky overflow. A clear takes priority over same-cycle traffic.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_overflow <= 1'b0;
      end else if (clr_err) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
         if (w_wr_req && w_full) r_overflow <= 1'b1;
      end
   end

   // FIFO storage.
   always_ff @(posedge clk) begin
      // NOTE: the storage array has no reset. Its contents are never observed until written, because the outputs are gated by out_valid.
      if (w_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= w_wr_entry;
   end

   assign w_head    = r_mem[r_rd_ptr[AW-1:0]];
   assign out_valid = ~w_empty;
   assign out_data  = out_valid ? w_head[7:0] : 8'd0;
   assign out_last  = out_valid & w_head[8];
   assign busy      = (r_state != S_IDLE);
   assign frame_err = r_frame_err;
   assign timeout   = r_timeout;
   assign overflow  = r_overflow;

endmodule
